// File: rtl/prog_instruction_memory.sv
// prog_instruction_memory
//
// Run-time loadable instruction store for the single-cycle CPU.
// A byte-serial load port assembles little-endian words and writes them
// sequentially from word 0. A request/valid fetch port returns registered
// reads with alignment and range checking. Fetches are held off while a
// load is in progress.
//
// Ports
//   clk             clock, all state updates on the rising edge
//   reset           asynchronous active-high reset
//   fetch_req       fetch request, accepted when fetch_ready=1
//   fetch_addr      byte address of the instruction
//   fetch_ready     high in IDLE only
//   fetch_valid     one-cycle response pulse
//   fetch_data      fetched word, 0 on fault, holds when fetch_valid=0
//   fetch_fault     misaligned or out-of-range fetch (with fetch_valid)
//   load_start      begins a load, honoured in IDLE only
//   load_byte_valid load_byte is valid this cycle
//   load_byte       program byte, little-endian within a word
//   load_last       final byte of the image (with load_byte_valid)
//   load_ready      high in LOAD
//   load_done       one-cycle pulse after the last word is written
//   load_overflow   sticky: bytes arrived after DEPTH words were written
//   load_words      words written in the current or last load
//
// state | meaning
// IDLE  | fetches accepted, waiting for load_start
// LOAD  | accepting image bytes, fetches blocked
// DONE  | load_done pulse, returns to IDLE next cycle

module prog_instruction_memory #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 16,
   parameter int DEPTH  = 1024
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     fetch_req,
   input  logic [ADDR_W-1:0]        fetch_addr,
   output logic                     fetch_ready,
   output logic                     fetch_valid,
   output logic [DATA_W-1:0]        fetch_data,
   output logic                     fetch_fault,
   input  logic                     load_start,
   input  logic                     load_byte_valid,
   input  logic [7:0]               load_byte,
   input  logic                     load_last,
   output logic                     load_ready,
   output logic                     load_done,
   output logic                     load_overflow,
   output logic [$clog2(DEPTH):0]   load_words
);

   localparam int NB  = DATA_W / 8;
   localparam int BL  = $clog2(NB);
   localparam int BIW = (BL > 0) ? BL : 1;
   localparam int AW  = ($clog2(DEPTH) > 0) ? $clog2(DEPTH) : 1;
   localparam int CW  = $clog2(DEPTH) + 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [DATA_W-1:0] mem [DEPTH];

   logic [BIW-1:0]    lane;
   logic [DATA_W-1:0] asm_q;
   logic [DATA_W-1:0] asm_next;
   logic              byte_acc;
   logic              full;
   logic              lane_last;
   logic              wr_en;

   logic [ADDR_W-1:0] word_idx;
   logic              misaligned;
   logic              out_of_range;
   logic              fault;
   logic              fetch_acc;

   // ------------------------------------------------------------------ FSM
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (load_start) state_nxt = S_LOAD;
         S_LOAD: if (load_byte_valid && load_last) state_nxt = S_DONE;
         S_DONE: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   assign fetch_ready = (state == S_IDLE);
   assign load_ready  = (state == S_LOAD);
   assign load_done   = (state == S_DONE);

   // ------------------------------------------------------------ load path
   assign byte_acc  = (state == S_LOAD) && load_byte_valid;
   assign full      = (load_words == CW'(DEPTH));
   assign lane_last = (lane == BIW'(NB - 1));
   assign asm_next  = asm_q | (DATA_W'(load_byte) << {lane, 3'b000});
   // A short final word is written with its unfilled lanes still zero.
   assign wr_en     = byte_acc && !full && (lane_last || load_last);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lane          <= '0;
         asm_q         <= '0;
         load_words    <= '0;
         load_overflow <= 1'b0;
      end else if (state == S_IDLE && load_start) begin
         lane          <= '0;
         asm_q         <= '0;
         load_words    <= '0;
         load_overflow <= 1'b0;
      end else if (byte_acc) begin
         if (full) begin
            load_overflow <= 1'b1;
         end else if (lane_last || load_last) begin
            lane       <= '0;
            asm_q      <= '0;
            load_words <= load_words + 1'b1;
         end else begin
            lane  <= lane + 1'b1;
            asm_q <= asm_next;
         end
      end
   end

   // Storage is deliberately not reset so a reset mid-load keeps the words
   // that were already written.
   always_ff @(posedge clk) begin
      if (wr_en) mem[load_words[AW-1:0]] <= asm_next;
   end

   // ----------------------------------------------------------- fetch path
   assign word_idx     = fetch_addr >> BL;
   assign misaligned   = (fetch_addr & ADDR_W'(NB - 1)) != '0;
   assign out_of_range = {1'b0, word_idx} >= (ADDR_W + 1)'(DEPTH);
   assign fault        = misaligned || out_of_range;
   assign fetch_acc    = fetch_req && fetch_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_valid <= 1'b0;
         fetch_data  <= '0;
         fetch_fault <= 1'b0;
      end else begin
         fetch_valid <= fetch_acc;
         if (fetch_acc) begin
            fetch_fault <= fault;
            fetch_data  <= fault ? '0 : mem[word_idx[AW-1:0]];
         end
      end
   end

endmodule

// File: tb/tb_prog_instruction_memory.sv
module tb_prog_instruction_memory;

   localparam int DEPTH = 1024;
   localparam int NBYTES = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        fetch_req;
   logic [15:0] fetch_addr;
   logic        fetch_ready;
   logic        fetch_valid;
   logic [31:0] fetch_data;
   logic        fetch_fault;
   logic        load_start;
   logic        load_byte_valid;
   logic [7:0]  load_byte;
   logic        load_last;
   logic        load_ready;
   logic        load_done;
   logic        load_overflow;
   logic [10:0] load_words;

   int vectors = 0;
   int errs    = 0;

   logic [31:0] model [DEPTH];
   logic [7:0]  img [$];

   prog_instruction_memory #(.DATA_W(32), .ADDR_W(16), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset),
      .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
      .fetch_valid(fetch_valid), .fetch_data(fetch_data), .fetch_fault(fetch_fault),
      .load_start(load_start), .load_byte_valid(load_byte_valid), .load_byte(load_byte),
      .load_last(load_last), .load_ready(load_ready), .load_done(load_done),
      .load_overflow(load_overflow), .load_words(load_words)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic exp_fault(input logic [15:0] a);
      return (a % NBYTES != 0) || (int'(a) / NBYTES >= DEPTH);
   endfunction

   function automatic logic [31:0] exp_data(input logic [15:0] a);
      if (exp_fault(a)) return 32'h0;
      return model[int'(a) / NBYTES];
   endfunction

   // Single fetch; also checks the one-cycle pulse and data hold afterwards.
   task automatic do_fetch(input logic [15:0] a);
      logic [31:0] e;
      @(negedge clk);
      chk("fetch_ready_idle", {31'b0, fetch_ready}, 32'd1);
      fetch_req = 1'b1; fetch_addr = a;
      e = exp_data(a);
      @(negedge clk);
      fetch_req = 1'b0;
      chk("fetch_valid", {31'b0, fetch_valid}, 32'd1);
      chk("fetch_data", fetch_data, e);
      chk("fetch_fault", {31'b0, fetch_fault}, {31'b0, exp_fault(a)});
      @(negedge clk);
      chk("fetch_valid_pulse", {31'b0, fetch_valid}, 32'd0);
      chk("fetch_data_hold", fetch_data, e);
   endtask

   function automatic logic [15:0] rand_addr();
      case ($urandom_range(0, 3))
         0: return 16'(4 * $urandom_range(0, 63));
         1: return 16'(4 * $urandom_range(0, 63) + $urandom_range(1, 3));
         2: return 16'($urandom_range(16'h1000, 16'hFFFF));
         default: return 16'($urandom_range(0, 16'hFFFF));
      endcase
   endfunction

   // Back-to-back fetches: a new request every cycle.
   task automatic fetch_burst(input int k);
      logic [15:0] a;
      @(negedge clk);
      for (int j = 0; j < k; j++) begin
         a = rand_addr();
         fetch_req = 1'b1; fetch_addr = a;
         @(negedge clk);
         chk("burst_valid", {31'b0, fetch_valid}, 32'd1);
         chk("burst_data", fetch_data, exp_data(a));
         chk("burst_fault", {31'b0, fetch_fault}, {31'b0, exp_fault(a)});
      end
      fetch_req = 1'b0;
      @(negedge clk);
      chk("burst_end_valid", {31'b0, fetch_valid}, 32'd0);
   endtask

   // Loads img; optionally issues a fetch in the load_start cycle and pokes
   // load_start again mid-load (which must be ignored).
   task automatic do_load(input bit with_fetch, input logic [15:0] faddr, input bit poke);
      int n;
      int ew;
      logic [31:0] pre;
      n = img.size();
      @(negedge clk);
      load_start = 1'b1;
      pre = exp_data(faddr);
      if (with_fetch) begin fetch_req = 1'b1; fetch_addr = faddr; end
      @(negedge clk);
      load_start = 1'b0; fetch_req = 1'b0;
      if (with_fetch) begin
         chk("start_fetch_valid", {31'b0, fetch_valid}, 32'd1);
         chk("start_fetch_data", fetch_data, pre);
      end
      chk("load_ready", {31'b0, load_ready}, 32'd1);
      chk("fetch_ready_load", {31'b0, fetch_ready}, 32'd0);
      chk("load_words_start", {21'b0, load_words}, 32'd0);
      chk("overflow_cleared", {31'b0, load_overflow}, 32'd0);
      for (int i = 0; i < n; i++) begin
         while ($urandom_range(0, 3) == 0) begin
            load_byte_valid = 1'b0;
            @(negedge clk);
         end
         load_byte_valid = 1'b1;
         load_byte = img[i];
         load_last = (i == n - 1);
         load_start = poke && (i == n / 2);
         fetch_req = poke && (i == n / 2);
         @(negedge clk);
      end
      load_byte_valid = 1'b0; load_last = 1'b0; load_start = 1'b0; fetch_req = 1'b0;
      for (int i = 0; i < n; i++) begin
         if (i / NBYTES < DEPTH) begin
            if (i % NBYTES == 0) model[i / NBYTES] = 32'h0;
            model[i / NBYTES][8 * (i % NBYTES) +: 8] = img[i];
         end
      end
      ew = (n + NBYTES - 1) / NBYTES;
      if (ew > DEPTH) ew = DEPTH;
      chk("load_done", {31'b0, load_done}, 32'd1);
      chk("fetch_ready_done", {31'b0, fetch_ready}, 32'd0);
      chk("load_ready_done", {31'b0, load_ready}, 32'd0);
      chk("load_words", {21'b0, load_words}, 32'(ew));
      chk("load_overflow", {31'b0, load_overflow}, {31'b0, n > DEPTH * NBYTES});
      @(negedge clk);
      chk("load_done_pulse", {31'b0, load_done}, 32'd0);
      chk("fetch_ready_back", {31'b0, fetch_ready}, 32'd1);
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
      reset = 1'b1;
      fetch_req = 1'b0; fetch_addr = '0;
      load_start = 1'b0; load_byte_valid = 1'b0; load_byte = '0; load_last = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_fetch_valid", {31'b0, fetch_valid}, 32'd0);
      chk("rst_fetch_data", fetch_data, 32'd0);
      chk("rst_fetch_fault", {31'b0, fetch_fault}, 32'd0);
      chk("rst_fetch_ready", {31'b0, fetch_ready}, 32'd1);
      chk("rst_load_ready", {31'b0, load_ready}, 32'd0);
      chk("rst_load_done", {31'b0, load_done}, 32'd0);
      chk("rst_overflow", {31'b0, load_overflow}, 32'd0);
      chk("rst_load_words", {21'b0, load_words}, 32'd0);
      reset = 1'b0;

      do_fetch(16'h0000);

      img = '{8'h20, 8'h00, 8'h00, 8'h00, 8'h21, 8'h00, 8'h00, 8'h00};
      do_load(1'b0, 16'h0, 1'b0);
      do_fetch(16'h0000);
      do_fetch(16'h0004);

      // Fetch in the load_start cycle must see the pre-load word 0.
      img = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      do_load(1'b1, 16'h0000, 1'b0);
      do_fetch(16'h0000);
      do_fetch(16'h0004);
      do_fetch(16'h0002);
      do_fetch(16'h1000);
      do_fetch(16'h0FFC);

      for (int r = 0; r < 6; r++) begin
         int n;
         n = $urandom_range(1, 40);
         img.delete();
         for (int i = 0; i < n; i++) img.push_back(8'($urandom_range(0, 255)));
         do_load(1'($urandom_range(0, 1)), rand_addr(), 1'($urandom_range(0, 1)));
         fetch_burst(12);
      end

      // Overflow: 4100 bytes into 1024 words, last four bytes dropped.
      img.delete();
      for (int i = 0; i < DEPTH * NBYTES + 4; i++) img.push_back(8'($urandom_range(0, 255)));
      do_load(1'b0, 16'h0, 1'b0);
      do_fetch(16'h0FFC);
      do_fetch(16'h0000);
      img = '{8'hA5, 8'h5A};
      do_load(1'b0, 16'h0, 1'b0);
      do_fetch(16'h0000);
      do_fetch(16'h0004);

      // Reset after 6 bytes: word 0 stays written, partial word 1 discarded.
      img.delete();
      for (int i = 0; i < 6; i++) img.push_back(8'($urandom_range(0, 255)));
      @(negedge clk);
      load_start = 1'b1;
      @(negedge clk);
      load_start = 1'b0;
      for (int i = 0; i < 6; i++) begin
         load_byte_valid = 1'b1; load_byte = img[i];
         @(negedge clk);
      end
      load_byte_valid = 1'b0;
      model[0] = {img[3], img[2], img[1], img[0]};
      reset = 1'b1;
      #1;
      chk("midrst_fetch_ready", {31'b0, fetch_ready}, 32'd1);
      chk("midrst_load_ready", {31'b0, load_ready}, 32'd0);
      chk("midrst_load_done", {31'b0, load_done}, 32'd0);
      chk("midrst_load_words", {21'b0, load_words}, 32'd0);
      chk("midrst_fetch_data", fetch_data, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      chk("midrst_done_after", {31'b0, load_done}, 32'd0);
      do_fetch(16'h0000);
      do_fetch(16'h0004);
      chk("midrst_done_end", {31'b0, load_done}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
